fadd_prep_n36: RTL
==================

FADD_PREP_N36 -- requirements
Module: fadd_prep_n36

Interface
REQ-001 Parameter FRAC_WIDTH, default 36, is the significand width including the explicit leading bit.
REQ-002 Parameter EXP_WIDTH, default 8, is the biased exponent width.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  marks the operand set as valid.
REQ-006 Port in_ready  output  1  means the block accepts the operand set this cycle.
REQ-007 Port op_sub  input  1  selects A-B when 1 and A+B when 0.
REQ-008 Port sign_a, sign_b  input  1 each  are the operand signs.
REQ-009 Port exp_a, exp_b  input  EXP_WIDTH each  are the operand exponents.
REQ-010 Port mant_a, mant_b  input  FRAC_WIDTH each  are the operand significands.
REQ-011 Port out_valid  output  1  marks the prepared result as valid.
REQ-012 Port out_ready  input  1  means the downstream adder path accepts the result.
REQ-013 Port elarge_op, esmall_op  output  FRAC_WIDTH each  are the unshifted larger-exponent and smaller-exponent significands.
REQ-014 Port exp_f  output  EXP_WIDTH  is the larger exponent.
REQ-015 Port far_sign  output  1  is the sign of the larger-exponent operand after op_sub is applied to B.
REQ-016 Port exp_a_neq_b  output  1  is high when the exponents differ.
REQ-017 Port eff_sub  output  1  is the effective-subtraction flag.
REQ-018 Port path_close  output  1  selects the close path.
REQ-019 Port far_small_aligned  output  FRAC_WIDTH+2  is esmall_op shifted right by the exponent difference, including guard and round bits.
REQ-020 Port far_sticky  output  1  is the OR of all bits shifted out below the round bit.

Function
REQ-021 Handshake: input transfer occurs when in_valid and in_ready are both high; output transfer occurs when out_valid and out_ready are both high.
REQ-022 Pipeline is two register stages: S1 does compare/swap, S2 does align and path select; latency is 2 cycles with throughput 1 per cycle.
REQ-023 in_ready = !s1_valid | !s2_valid | out_ready; the pipeline is non-bubble-collapsing only when S2 is stalled.
REQ-024 While out_valid is high and out_ready is low, all outputs are held stable.
REQ-025 Effective B sign is sign_b^op_sub; eff_sub = sign_a ^ effective B sign.
REQ-026 Swap occurs when exp_b > exp_a; on equal exponents no swap occurs, so A is the large operand and far_sign = sign_a.
REQ-027 exp_diff = large exponent minus small exponent, unsigned; exp_a_neq_b = (exp_diff != 0).
REQ-028 path_close = eff_sub & (exp_diff <= 1).
REQ-029 far_small_aligned = {esmall_op,2'b00} >> exp_diff; far_sticky = OR of shifted-out bits.
REQ-030 When exp_diff >= FRAC_WIDTH+2, far_small_aligned = 0 and far_sticky = |esmall_op.
REQ-031 Far outputs are computed regardless of path_close; close-path outputs are passed through unshifted.

Reset
REQ-032 When rst is asserted, s1_valid and s2_valid clear, so out_valid = 0, and all data registers clear to 0.
REQ-033 in_ready reads 1 during and after reset.
REQ-034 Transactions in flight at reset are dropped without any output.

Structure
REQ-035 Package fadd_pkg holds FRAC_WIDTH, EXP_WIDTH, and the S1-to-S2 payload struct.
REQ-036 Sub-module fadd_rshift_sticky is a parameterized right shifter producing shifted value and sticky.

Verification
REQ-037 Scenario: exp_a=0x80, exp_b=0x80, op_sub=0, both signs 0 -> after 2 cycles: path_close=0, exp_a_neq_b=0, far_sticky=0, exp_f=0x80.
REQ-038 Scenario: exp_a=0x80, exp_b=0x81, sign_a=0, sign_b=1, op_sub=0 -> swap, exp_f=0x81, eff_sub=1, path_close=1, exp_a_neq_b=1, far_sign=1.
REQ-039 Scenario: exp_diff=40, esmall_op=0x8_0000_0001 -> far_small_aligned=0, far_sticky=1.
REQ-040 Scenario: exp_diff=3, esmall_op LSBs=3'b101 -> far_small_aligned ends in 2'b10, far_sticky=1.
REQ-041 Scenario: out_ready low for 3 cycles with 3 inputs offered -> 2 accepted, in_ready=0 on the third, outputs stable, order preserved on release.
REQ-042 Scenario: rst pulsed with 2 transactions in flight -> out_valid=0 next edge, no stale output afterwards.

Source files
------------

// File: rtl/fadd_pkg.sv
// Shared widths and the S1-to-S2 payload for the floating-point add
// pre-alignment pipeline.
package fadd_pkg;

   localparam int FRAC_WIDTH  = 36;
   localparam int EXP_WIDTH   = 8;
   localparam int ALIGN_WIDTH = FRAC_WIDTH + 2;  // significand plus guard and round

   // Operands after compare/swap, before alignment.
   typedef struct packed {
      logic [FRAC_WIDTH-1:0] elarge;
      logic [FRAC_WIDTH-1:0] esmall;
      logic [EXP_WIDTH-1:0]  exp_large;
      logic [EXP_WIDTH-1:0]  exp_diff;
      logic                  far_sign;
      logic                  eff_sub;
   } s1_payload_t;

endpackage

// File: rtl/fadd_rshift_sticky.sv
// Right shifter that also reports whether any set bit fell off the bottom.
module fadd_rshift_sticky
   import fadd_pkg::*;
#(
   parameter int WIDTH       = ALIGN_WIDTH,
   parameter int SHIFT_WIDTH = EXP_WIDTH
) (
   input  logic [WIDTH-1:0]       value,
   input  logic [SHIFT_WIDTH-1:0] amount,
   output logic [WIDTH-1:0]       shifted,
   output logic                   sticky
);

   logic [WIDTH-1:0] lost_mask;

   // A shift of WIDTH or more yields zero here and an all-ones loss mask,
   // which is exactly the "everything shifted out" case.
   assign shifted   = value >> amount;
   assign lost_mask = ~({WIDTH{1'b1}} << amount);
   assign sticky    = |(value & lost_mask);

endmodule

// File: rtl/fadd_prep_n36.sv
// Two-stage add/sub preparation: S1 compares and swaps operands, S2 aligns the
// smaller significand and selects between close and far paths.
module fadd_prep_n36 #(
   parameter int FRAC_WIDTH = fadd_pkg::FRAC_WIDTH,
   parameter int EXP_WIDTH  = fadd_pkg::EXP_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  op_sub,
   input  logic                  sign_a,
   input  logic                  sign_b,
   input  logic [EXP_WIDTH-1:0]  exp_a,
   input  logic [EXP_WIDTH-1:0]  exp_b,
   input  logic [FRAC_WIDTH-1:0] mant_a,
   input  logic [FRAC_WIDTH-1:0] mant_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FRAC_WIDTH-1:0] elarge_op,
   output logic [FRAC_WIDTH-1:0] esmall_op,
   output logic [EXP_WIDTH-1:0]  exp_f,
   output logic                  far_sign,
   output logic                  exp_a_neq_b,
   output logic                  eff_sub,
   output logic                  path_close,
   output logic [FRAC_WIDTH+1:0] far_small_aligned,
   output logic                  far_sticky
);

   fadd_pkg::s1_payload_t s1_d;
   fadd_pkg::s1_payload_t s1_q;

   logic s1_valid;
   logic s2_valid;
   logic s1_load;
   logic s2_load;
   logic swap;
   logic sign_b_eff;

   logic [FRAC_WIDTH+1:0] align_shifted;
   logic                  align_sticky;
   logic                  close_sel;

   // S2 refills whenever it is empty or draining; S1 frees whenever S2 refills,
   // so accepting under this condition never overwrites live data.
   assign in_ready  = !s1_valid || !s2_valid || out_ready;
   assign s1_load   = in_valid && in_ready;
   assign s2_load   = s1_valid && (!s2_valid || out_ready);
   assign out_valid = s2_valid;

   // Stage 1: compare exponents, swap so the larger-exponent operand leads.
   always_comb begin
      s1_d       = '0;
      swap       = exp_b > exp_a;
      sign_b_eff = sign_b ^ op_sub;

      s1_d.eff_sub = sign_a ^ sign_b_eff;
      if (swap) begin
         s1_d.elarge    = mant_b;
         s1_d.esmall    = mant_a;
         s1_d.exp_large = exp_b;
         s1_d.exp_diff  = exp_b - exp_a;
         s1_d.far_sign  = sign_b_eff;
      end else begin
         s1_d.elarge    = mant_a;
         s1_d.esmall    = mant_b;
         s1_d.exp_large = exp_a;
         s1_d.exp_diff  = exp_a - exp_b;
         s1_d.far_sign  = sign_a;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= 1'b1;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end

         if (s2_load) begin
            s2_valid <= 1'b1;
         end else if (out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

   // NOTE: data registers are reset too, so outputs read as zero after reset
   // rather than leftover values; the cost is a reset net on every flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
      end else if (s1_load) begin
         s1_q <= s1_d;
      end
   end

   // Stage 2: far-path alignment is always computed; the close path just
   // consumes the unshifted operands.
   fadd_rshift_sticky #(
      .WIDTH       (FRAC_WIDTH + 2),
      .SHIFT_WIDTH (EXP_WIDTH)
   ) u_align (
      .value   ({s1_q.esmall, 2'b00}),
      .amount  (s1_q.exp_diff),
      .shifted (align_shifted),
      .sticky  (align_sticky)
   );

   assign close_sel = s1_q.eff_sub && (s1_q.exp_diff <= EXP_WIDTH'(1));

   // Output registers load only on S2 advance, which holds them during a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elarge_op         <= '0;
         esmall_op         <= '0;
         exp_f             <= '0;
         far_sign          <= 1'b0;
         exp_a_neq_b       <= 1'b0;
         eff_sub           <= 1'b0;
         path_close        <= 1'b0;
         far_small_aligned <= '0;
         far_sticky        <= 1'b0;
      end else if (s2_load) begin
         elarge_op         <= s1_q.elarge;
         esmall_op         <= s1_q.esmall;
         exp_f             <= s1_q.exp_large;
         far_sign          <= s1_q.far_sign;
         exp_a_neq_b       <= |s1_q.exp_diff;
         eff_sub           <= s1_q.eff_sub;
         path_close        <= close_sel;
         far_small_aligned <= align_shifted;
         far_sticky        <= align_sticky;
      end
   end

endmodule
